board_in_conditioner: RTL
=========================

Name: board_in_conditioner

Overview:
Per-bit input conditioner for the 8 board switches/buttons. It sits directly upstream of the board input PIO slave and drives that slave's in_port. Raw asynchronous pins are synchronised, debounced and edge-detected. Detected changes are held in a sticky edge-capture register that raises an interrupt.

Parameters:
WIDTH, 8, number of input bits.
SYNC_STAGES, 2, synchroniser flops per bit; legal range 2..4.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a change is accepted; must be >= 1.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
RESET_VALUE, 0 (WIDTH bits), reset value of clean_out and of the synchroniser flops.

Ports:
clk  input  1  system clock.
reset_n  input  1  reset, asynchronous, active-low.
raw_in  input  WIDTH  asynchronous board pins.
clr_edge  input  WIDTH  one-cycle clear strobes for edge_capture bits.
irq_mask  input  WIDTH  per-bit interrupt enable.
clean_out  output  WIDTH  debounced level; drives the PIO slave in_port.
rise_pulse  output  WIDTH  one-cycle pulse on an accepted 0->1 change.
fall_pulse  output  WIDTH  one-cycle pulse on an accepted 1->0 change.
edge_capture  output  WIDTH  sticky record of accepted changes.
irq  output  1  interrupt request.

Behaviour:
- Reset (async assert, sync release):
  - sync chain and clean_out = RESET_VALUE.
  - Counters = 0.
  - rise_pulse, fall_pulse, edge_capture = 0; irq = 0.
- Synchroniser: SYNC_STAGES flops per bit. s[i] is the last stage. No logic is placed between the stages.
- Debounce, per bit, all registered on posedge clk:
  - s[i] == clean_out[i]: cnt[i] <= 0.
  - s[i] != clean_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != clean_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: clean_out[i] <= s[i]; cnt[i] <= 0.
  - Any single matching cycle during a pending change restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Latency: clean_out changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after a stable raw change. Count from and including the first edge that samples the new raw value.
- Pulses:
  - rise_pulse[i] / fall_pulse[i] are registered on the same edge that updates clean_out[i].
  - Each is high for exactly one cycle.
  - rise and fall are never high together for the same bit.
- Edge capture:
  - edge_capture[i] <= 1 on any cycle where rise_pulse[i] or fall_pulse[i] is being set.
  - Otherwise edge_capture[i] <= 0 when clr_edge[i] = 1; otherwise it holds.
  - Simultaneous set and clear on the same bit: set wins.
- irq: registered; irq <= |(edge_capture & irq_mask). It deasserts one cycle after the last relevant bit clears or is masked.
- Bits are fully independent. Multiple bits may change, pulse and capture in the same cycle.
- Reset mid-debounce: the pending count is discarded. After release, clean_out = RESET_VALUE, and a raw level that differs must again satisfy the full latency. No pulse is generated by reset itself.
- Power-up case: when raw_in differs from RESET_VALUE at reset release, the change is accepted after the normal latency and produces a normal pulse and capture.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0):
- Reset, then raw_in=0x00 held for 20 cycles -> clean_out=0x00, pulses=0, edge_capture=0x00, irq=0.
- raw_in 0x00->0x01 held -> clean_out=0x01 exactly 6 edges after the first sampling edge. rise_pulse=0x01 for 1 cycle. edge_capture=0x01. With irq_mask=0x01, irq=1 one cycle later.
- raw_in[3] toggled high for 3 cycles then low; repeat 5 times -> clean_out[3] stays 0, no pulses, edge_capture[3]=0.
- Bit 0 accepted high, then clr_edge=0x01 on the same cycle as a new fall_pulse[0] -> edge_capture[0] remains 1. A later clr_edge=0x01 alone -> edge_capture[0]=0 and irq drops next cycle.
- raw_in 0x00->0xA5 in one cycle -> clean_out=0xA5 after 6 edges. rise_pulse=0xA5 for 1 cycle. Then raw_in=0x00 -> fall_pulse=0xA5 after 6 edges.
- raw_in=0xFF held, reset_n pulsed low when cnt=2 -> after release clean_out=0x00, then 0xFF after 6 edges. No pulse during reset.

Source files
------------

// File: rtl/board_in_conditioner.sv
// Per-bit conditioner for board switches and buttons. Each pin passes through a
// synchroniser and a debouncer. Accepted level changes produce one-cycle
// rise/fall pulses, which set a sticky edge-capture register that can raise an
// interrupt.
module board_in_conditioner #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr_edge,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  // Terminal count: the change is accepted when this value is reached, so the
  // counter never needs to wrap.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Plain flop chain: no logic between the stages, so metastability can settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Debounce each bit independently. A single matching cycle restarts the count.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      cnt_d[b] = '0;
      if (sync_s[b] != clean_q[b]) begin
        if (cnt_q[b] == CntMax) begin
          clean_d[b] = sync_s[b];
          rise_d[b]  = sync_s[b];
          fall_d[b]  = ~sync_s[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // Edge capture gives priority to a new set over a clear. The irq output is one
  // cycle behind the capture register.
  always_comb begin
    edge_d = (edge_q & ~clr_edge) | rise_d | fall_d;
    irq_d  = |(edge_q & irq_mask);
  end

  // Debounce, pulse, capture and irq state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
      clean_q <= RESET_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
    end
  end

  assign clean_out    = clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign edge_capture = edge_q;
  assign irq          = irq_q;

endmodule
